// File: rtl/bus_port_fifo.sv
// Per-slot bus port: TX FIFO feeding the arbiter pop port, RX FIFO fed by ID-filtered bus pushes.
// Optional define BUS_PORT_BCAST_EN: also accept destination ID 8'hFF as broadcast.
module bus_port_fifo #(
    parameter int          pckg_sz   = 16,
    parameter int          deep_fifo = 8,
    parameter logic [7:0]  MY_ID     = 8'h00
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_push,
    input  logic [pckg_sz-1:0]           tx_data,
    output logic                         tx_full,
    output logic [$clog2(deep_fifo):0]   tx_count,
    output logic                         tx_ovf,
    output logic                         pndng,
    output logic [pckg_sz-1:0]           D_pop,
    input  logic                         pop,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    output logic                         rx_valid,
    output logic [pckg_sz-1:0]           rx_data,
    input  logic                         rx_ready,
    output logic [7:0]                   rx_drop_cnt
);

    localparam int aw = $clog2(deep_fifo);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full_cnt = cw'(deep_fifo);

    logic [pckg_sz-1:0] tx_mem [deep_fifo];
    logic [aw-1:0]      tx_wptr, tx_rptr;
    logic [cw-1:0]      tx_cnt;
    logic               tx_empty, tx_rd, tx_wr;

    logic [pckg_sz-1:0] rx_mem [deep_fifo];
    logic [aw-1:0]      rx_wptr, rx_rptr;
    logic [cw-1:0]      rx_cnt;
    logic               rx_empty, rx_full, rx_rd, rx_wr, rx_match, rx_drop;
    logic [7:0]         dest_id;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == full_cnt);
    assign tx_rd    = pop && !tx_empty;
    // A full FIFO still accepts a write when the arbiter frees the head slot this cycle.
    assign tx_wr    = tx_push && (!tx_full || tx_rd);

    assign tx_count = tx_cnt;
    assign pndng    = !tx_empty;
    assign D_pop    = tx_empty ? '0 : tx_mem[tx_rptr];

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            tx_ovf  <= 1'b0;
        end else begin
            if (tx_wr) tx_wptr <= tx_wptr + 1'b1;
            if (tx_rd) tx_rptr <= tx_rptr + 1'b1;
            if (tx_wr && !tx_rd)      tx_cnt <= tx_cnt + 1'b1;
            else if (tx_rd && !tx_wr) tx_cnt <= tx_cnt - 1'b1;
            if (tx_push && !tx_wr) tx_ovf <= 1'b1;
        end
    end

    assign dest_id = D_push[pckg_sz-1 -: 8];

`ifdef BUS_PORT_BCAST_EN
    assign rx_match = push && ((dest_id == MY_ID) || (dest_id == 8'hFF));
`else
    assign rx_match = push && (dest_id == MY_ID);
`endif

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == full_cnt);
    assign rx_valid = !rx_empty;
    assign rx_rd    = rx_valid && rx_ready;
    assign rx_wr    = rx_match && (!rx_full || rx_rd);
    assign rx_drop  = rx_match && !rx_wr;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rptr];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr] <= D_push;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_cnt      <= '0;
            rx_drop_cnt <= 8'd0;
        end else begin
            if (rx_wr) rx_wptr <= rx_wptr + 1'b1;
            if (rx_rd) rx_rptr <= rx_rptr + 1'b1;
            if (rx_wr && !rx_rd)      rx_cnt <= rx_cnt + 1'b1;
            else if (rx_rd && !rx_wr) rx_cnt <= rx_cnt - 1'b1;
            if (rx_drop && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (MY_ID=2, depth 8); broadcast expectations follow BUS_PORT_BCAST_EN.
module tb_bus_port_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_push;
    logic [15:0] tx_data;
    logic        tx_full;
    logic [3:0]  tx_count;
    logic        tx_ovf;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic [7:0]  rx_drop_cnt;

    int total = 0;
    int bad   = 0;

    bus_port_fifo #(.pckg_sz(16), .deep_fifo(8), .MY_ID(8'h02)) dut (
        .clk(clk), .reset(reset),
        .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
        .tx_ovf(tx_ovf), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_out();
        return {16'd0, pndng, tx_full, tx_ovf, rx_valid, tx_count, D_pop, rx_data, rx_drop_cnt};
    endfunction

    initial begin
        reset = 1'b1; tx_push = 1'b0; tx_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("idle_outputs", all_out(), 64'd0);
            tick();
        end
        pop = 1'b1; rx_ready = 1'b1;
        tick();
        check_eq("empty_pop_count", 64'(tx_count), 64'd0);
        check_eq("empty_pop_outputs", all_out(), 64'd0);
        pop = 1'b0; rx_ready = 1'b0;

        // TX ordering
        tx_push = 1'b1; tx_data = 16'h0202;
        tick();
        check_eq("tx_first_pndng", 64'(pndng), 64'd1);
        check_eq("tx_first_head", 64'(D_pop), 64'h0202);
        tx_data = 16'h0203; tick();
        tx_data = 16'h0204; tick();
        tx_push = 1'b0;
        check_eq("tx_count3", 64'(tx_count), 64'd3);
        pop = 1'b1;
        tick(); check_eq("tx_head_0203", 64'(D_pop), 64'h0203);
        tick(); check_eq("tx_head_0204", 64'(D_pop), 64'h0204);
        tick(); check_eq("tx_head_empty", 64'(D_pop), 64'h0);
        check_eq("tx_pndng_empty", 64'(pndng), 64'd0);
        pop = 1'b0;

        // TX overflow without pop
        tx_push = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 16'h0300 + 16'(i);
            tick();
        end
        tx_push = 1'b0;
        check_eq("ovf_full", 64'(tx_full), 64'd1);
        check_eq("ovf_count", 64'(tx_count), 64'd8);
        check_eq("ovf_flag", 64'(tx_ovf), 64'd1);
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_drain_order", 64'(D_pop), 64'h0300 + 64'(i));
            tick();
        end
        pop = 1'b0;
        check_eq("ovf_9th_absent", 64'(pndng), 64'd0);
        check_eq("ovf_sticky", 64'(tx_ovf), 64'd1);

        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("ovf_cleared", 64'(tx_ovf), 64'd0);

        // Full plus same-cycle pop accepts the ninth push
        tx_push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'h0300 + 16'(i);
            tick();
        end
        tx_data = 16'h0308; pop = 1'b1;
        tick();
        tx_push = 1'b0;
        check_eq("fullpop_count", 64'(tx_count), 64'd8);
        check_eq("fullpop_no_ovf", 64'(tx_ovf), 64'd0);
        for (int i = 1; i < 9; i++) begin
            check_eq("fullpop_order", 64'(D_pop), 64'h0300 + 64'(i));
            tick();
        end
        pop = 1'b0;
        check_eq("fullpop_empty", 64'(pndng), 64'd0);

        // RX filter
        push = 1'b1; D_push = 16'h0203;
        tick();
        check_eq("rx_latency", 64'(rx_valid), 64'd1);
        D_push = 16'h0102;
        tick();
        push = 1'b0;
        check_eq("rx_filter_head", 64'(rx_data), 64'h0203);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("rx_filter_only_one", 64'(rx_valid), 64'd0);
        check_eq("rx_filter_no_drop", 64'(rx_drop_cnt), 64'd0);

        // RX full and drop counting
        push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            D_push = 16'h0210 + 16'(i);
            tick();
        end
        push = 1'b0;
        check_eq("rx_drop_cnt2", 64'(rx_drop_cnt), 64'd2);
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("rx_drain_order", 64'(rx_data), 64'h0210 + 64'(i));
            tick();
        end
        check_eq("rx_drained", 64'(rx_valid), 64'd0);
        rx_ready = 1'b0;

        // RX full with same-cycle read accepts the match
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h0220 + 16'(i);
            tick();
        end
        D_push = 16'h0228; rx_ready = 1'b1;
        tick();
        push = 1'b0;
        check_eq("rx_fullread_nodrop", 64'(rx_drop_cnt), 64'd2);
        for (int i = 1; i < 9; i++) begin
            check_eq("rx_fullread_order", 64'(rx_data), 64'h0220 + 64'(i));
            tick();
        end
        check_eq("rx_fullread_empty", 64'(rx_valid), 64'd0);
        rx_ready = 1'b0;

        // Broadcast ID
        push = 1'b1; D_push = 16'hFF55;
        tick();
        push = 1'b0;
`ifdef BUS_PORT_BCAST_EN
        check_eq("bcast_valid", 64'(rx_valid), 64'd1);
        check_eq("bcast_data", 64'(rx_data), 64'hFF55);
`else
        check_eq("bcast_valid", 64'(rx_valid), 64'd0);
        check_eq("bcast_data", 64'(rx_data), 64'h0);
`endif
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;

        // Mid-operation reset with both FIFOs half full
        tx_push = 1'b1; push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 16'h0400 + 16'(i);
            D_push  = 16'h0240 + 16'(i);
            tick();
        end
        check_eq("half_tx_count", 64'(tx_count), 64'd4);
        check_eq("half_rx_head", 64'(rx_data), 64'h0240);
        reset = 1'b1;
        tick();
        check_eq("reset_outputs", all_out(), 64'd0);
        reset = 1'b0; tx_push = 1'b0; push = 1'b0;
        tick();
        check_eq("reset_inputs_ignored", all_out(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
